fixed_to_float: RTL and testbench

//  Converts a signed fixed-point CORDIC result (sin/cos, FRACTIONAL_BITS frac bits) back into an

---
 rtl/fixed_to_float.sv | 101 ++++++++++
 tb/tb_fixed_to_float.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Signed fixed-point (sin/cos CORDIC output) to IEEE-754 single converter.
// Normalises one bit per cycle, rounds to nearest-even, packs; start/done handshake.
module fixed_to_float #(
  parameter int FRACTIONAL_BITS = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic        busy,
  output logic [31:0] result
);
  localparam int W = FRACTIONAL_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_NORM, S_ROUND, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [7:0]     exp_q, exp_d;
  logic           sign_q, sign_d;
  logic [31:0]    result_q, result_d;

  // Left-align the normalised magnitude in 32 bits so one rounding path covers every W:
  // for W<=24 the guard/sticky bits are simply zero.
  logic [31:0]    m32;
  logic [22:0]    mant_raw, mant_r;
  logic [23:0]    mant_sum;
  logic [7:0]     exp_r;
  logic           g_bit, s_bit, rnd_up;
  logic           unused_bits;

  assign m32      = 32'(mag_q) << (32 - W);
  assign mant_raw = m32[30:8];
  assign g_bit    = m32[7];
  assign s_bit    = |m32[6:0];
  assign rnd_up   = g_bit & (s_bit | mant_raw[0]);
  assign mant_sum = {1'b0, mant_raw} + 24'(rnd_up);
  assign mant_r   = mant_sum[23] ? 23'd0 : mant_sum[22:0];
  assign exp_r    = mant_sum[23] ? exp_q + 8'd1 : exp_q;

  assign unused_bits = ^{dataa, m32[31]};

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (start) begin
        mag_d   = dataa[W-1:0];
        state_d = S_ABS;
      end
      S_ABS: begin
        sign_d = mag_q[W-1];
        mag_d  = mag_q[W-1] ? -mag_q : mag_q;
        if (mag_q == '0) begin
          result_d = 32'h0000_0000;
          state_d  = S_DONE;
        end else begin
          exp_d   = 8'd128;
          state_d = S_NORM;
        end
      end
      S_NORM: if (mag_q[W-1]) begin
        state_d = S_ROUND;
      end else begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 8'd1;
      end
      S_ROUND: begin
        result_d = {sign_q, exp_r, mant_r};
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == S_DONE);
  assign busy   = (state_q != S_IDLE);
  assign result = result_q;
endmodule

// File: tb/tb_fixed_to_float.sv
// Bench for fixed_to_float: F=22 instance tracked every cycle by an arithmetic model,
// F=30 instance for the rounding corner cases, plus directed literal vectors.
module tb_fixed_to_float;
  logic        clk, reset_n, clk_en;
  logic        start, start30;
  logic [31:0] dataa, dataa30;
  logic        done, busy, done30, busy30;
  logic [31:0] result, result30;

  int nchk = 0;
  int nerr = 0;

  fixed_to_float #(.FRACTIONAL_BITS(22)) dut22 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .busy(busy), .result(result));

  fixed_to_float #(.FRACTIONAL_BITS(30)) dut30 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start30), .dataa(dataa30),
    .done(done30), .busy(busy30), .result(result30));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Signed value of the low W bits, as a 64-bit integer.
  function automatic longint sval(input logic [31:0] d, input int f);
    longint x;
    x = longint'(d) & ((64'sd1 << (f + 2)) - 1);
    if (x >= (64'sd1 << (f + 1))) x -= (64'sd1 << (f + 2));
    return x;
  endfunction

  function automatic int msb(input longint m);
    int p = -1;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic logic [31:0] mdl(input logic [31:0] d, input int f);
    longint x, mag, q, rem, half;
    int p, e, sh;
    logic sg;
    x   = sval(d, f);
    sg  = (x < 0);
    mag = sg ? -x : x;
    if (mag == 0) return 32'h0;
    p = msb(mag);
    e = 127 + p - f;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 << 24)) begin
        q = 64'sd1 << 23;
        e++;
      end
    end
    return {sg, e[7:0], q[22:0]};
  endfunction

  function automatic int mlat(input logic [31:0] d, input int f);
    longint x, mag;
    x   = sval(d, f);
    mag = (x < 0) ? -x : x;
    if (mag == 0) return 2;
    return 4 + (f + 1 - msb(mag));
  endfunction

  // Protocol-level model of the F=22 instance: pending job, cycles to done, held result.
  logic        m_pend;
  int          m_rem;
  logic [31:0] m_new, m_held;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend <= 1'b0;
      m_rem  <= 0;
      m_new  <= '0;
      m_held <= '0;
    end else if (clk_en) begin
      if (!m_pend) begin
        if (start) begin
          m_pend <= 1'b1;
          m_rem  <= mlat(dataa, 22) - 1;
          m_new  <= mdl(dataa, 22);
        end
      end else if (m_rem == 0) begin
        m_pend <= 1'b0;
        m_held <= m_new;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc busy", 32'(busy), 32'(m_pend));
      chk("cyc done", 32'(done), 32'(m_pend && m_rem == 0));
      chk("cyc result", result, (m_pend && m_rem == 0) ? m_new : m_held);
    end
  end

  // Start at cycle 0, expect done in cycle el with result er. fz>0 drops clk_en for
  // cycles fz..fz+2; ham keeps start asserted with junk data while busy.
  task automatic conv(input bit s30, input logic [31:0] d, input logic [31:0] er,
                      input int el, input int fz, input bit ham, input string nm);
    bit seen = 1'b0;
    int c = 0;
    if (s30) begin start30 = 1'b1; dataa30 = d; end
    else     begin start   = 1'b1; dataa   = d; end
    while (!seen && c < 80) begin
      @(negedge clk);
      if (s30 ? done30 : done) begin
        seen = 1'b1;
        chk({nm, " latency"}, 32'(c), 32'(el));
        chk({nm, " result"}, s30 ? result30 : result, er);
        chk({nm, " model"}, mdl(d, s30 ? 30 : 22), er);
      end
      @(posedge clk); #1;
      c++;
      start   = 1'b0;
      start30 = 1'b0;
      if (ham && c <= el) begin
        if (s30) begin start30 = 1'b1; dataa30 = $urandom; end
        else     begin start   = 1'b1; dataa   = $urandom; end
      end
      clk_en = !(fz > 0 && c >= fz && c < fz + 3);
    end
    if (!seen) begin
      nchk++; nerr++;
      $display("FAIL %s timeout: no done within 80 cycles, expected cycle %0d", nm, el);
    end
    clk_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b1;
    start = 1'b0; start30 = 1'b0; dataa = '0; dataa30 = '0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset result30", result30, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    conv(0, 32'h0040_0000, 32'h3F80_0000, 5,  0, 0, "+1.0");
    conv(0, 32'h00C0_0000, 32'hBF80_0000, 5,  0, 0, "-1.0");
    conv(0, 32'h0020_0000, 32'h3F00_0000, 6,  0, 0, "+0.5");
    conv(0, 32'h0080_0000, 32'hC000_0000, 4,  0, 0, "-2.0");
    conv(0, 32'h0000_0000, 32'h0000_0000, 2,  0, 0, "zero");
    conv(0, 32'h0000_0001, 32'h3480_0000, 27, 0, 0, "lsb");
    conv(0, 32'hFF00_0001, 32'h3480_0000, 27, 0, 0, "lsb upper");
    conv(0, 32'h00FF_FFFF, 32'hB480_0000, 27, 0, 0, "-lsb");
    conv(0, 32'h003F_FFFF, 32'h3F7F_FFFC, 6,  0, 0, "near1");
    conv(0, 32'h0060_0000, 32'h3FC0_0000, 5,  0, 0, "+1.5");
    conv(0, 32'h0040_0000, 32'h3F80_0000, 8,  2, 0, "clk_en freeze");
    conv(0, 32'h0020_0000, 32'h3F00_0000, 6,  0, 1, "start while busy");

    conv(1, 32'h7FFF_FFFF, 32'h4000_0000, 5, 0, 0, "f30 carry");
    conv(1, 32'h4000_0040, 32'h3F80_0000, 5, 0, 0, "f30 tie even");
    conv(1, 32'h4000_00C0, 32'h3F80_0002, 5, 0, 0, "f30 tie odd");
    conv(1, 32'h8000_0000, 32'hC000_0000, 4, 0, 0, "f30 -2.0");

    // abort a long conversion with reset while busy
    start = 1'b1; dataa = 32'h0000_0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort result30", result30, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    conv(0, 32'h0040_0000, 32'h3F80_0000, 5, 0, 0, "after reset");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
